// File: rtl/led_scan_pkg.sv
// rtl/led_scan_pkg.sv - shared state type and helpers for the LED matrix scanner
package led_scan_pkg;

  typedef enum logic {BLANK = 1'b0, SHOW = 1'b1} scan_state_e;

  localparam int MAX_COLS           = 16;
  localparam int DWELL_BITS_DEFAULT = 10;
  localparam int DWELL_CYCLES       = 1 << DWELL_BITS_DEFAULT;

  function automatic int dwell_cycles(input int dwell_bits);
    return 1 << dwell_bits;
  endfunction

  function automatic logic [MAX_COLS-1:0] col_onehot(input int unsigned col,
                                                     input int unsigned cols);
    logic [MAX_COLS-1:0] v;
    v = '0;
    if (col < cols) v = MAX_COLS'(1) << col;
    return v;
  endfunction

endpackage

// File: rtl/led_scan_timer.sv
// rtl/led_scan_timer.sv - blank/dwell phase counter and column index for the scanner
module led_scan_timer
  import led_scan_pkg::*;
#(
  parameter int COLS         = 4,
  parameter int DWELL_BITS   = 10,
  parameter int BLANK_CYCLES = 16,
  parameter int PWM_BITS     = 4,
  localparam int CIW         = $clog2(COLS)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                clr_i,
  input  logic                show_i,
  output logic                phase_done_o,
  output logic                first_o,
  output logic [CIW-1:0]      col_o,
  output logic [PWM_BITS-1:0] p_o
);

  localparam int BW = $clog2(BLANK_CYCLES + 1);
  localparam int CW = (DWELL_BITS > BW) ? DWELL_BITS : BW;
  // A zero-length blank still occupies one cycle so adjacent columns never overlap.
  localparam logic [CW-1:0]  BLANK_LAST = CW'((BLANK_CYCLES == 0) ? 0 : BLANK_CYCLES - 1);
  localparam logic [CW-1:0]  SHOW_LAST  = CW'(dwell_cycles(DWELL_BITS) - 1);
  localparam logic [CIW-1:0] COL_LAST   = CIW'(COLS - 1);

  logic [CW-1:0]  cnt_q, cnt_d;
  logic [CIW-1:0] col_q, col_d;

  always_comb begin
    phase_done_o = (cnt_q == (show_i ? SHOW_LAST : BLANK_LAST));
    cnt_d        = phase_done_o ? '0 : cnt_q + CW'(1);
    col_d        = col_q;
    if (show_i && phase_done_o) col_d = (col_q == COL_LAST) ? '0 : col_q + CIW'(1);
    if (clr_i) begin
      cnt_d = '0;
      col_d = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      col_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      col_q <= col_d;
    end
  end

  assign first_o = (cnt_q == '0);
  assign col_o   = col_q;
  assign p_o     = cnt_q[DWELL_BITS-1 -: PWM_BITS];

endmodule

// File: rtl/led_scan_matrix.sv
// rtl/led_scan_matrix.sv - column-scanned LED matrix driver with blanking, PWM and frame snapshot
module led_scan_matrix
  import led_scan_pkg::*;
#(
  parameter int ROWS           = 8,
  parameter int COLS           = 4,
  parameter int DWELL_BITS     = 10,
  parameter int BLANK_CYCLES   = 16,
  parameter int PWM_BITS       = 4,
  parameter int COL_ACTIVE_LOW = 1,
  parameter int ROW_ACTIVE_LOW = 0
) (
  input  logic                   clk12MHz,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [ROWS*COLS-1:0]   leds_in,
  input  logic [PWM_BITS-1:0]    brightness,
  output logic [ROWS-1:0]        leds,
  output logic [COLS-1:0]        lcol,
  output logic                   frame_start
);

  localparam int CIW = $clog2(COLS);
  localparam logic [ROWS-1:0] ROW_OFF = {ROWS{ROW_ACTIVE_LOW != 0}};
  localparam logic [COLS-1:0] COL_OFF = {COLS{COL_ACTIVE_LOW != 0}};

  scan_state_e            state_q, state_d;
  logic [ROWS*COLS-1:0]   snap_q, snap_d;
  logic [ROWS-1:0]        leds_q, leds_d, rows_act;
  logic [COLS-1:0]        lcol_q, lcol_d, cols_act;
  logic                   fs_q, fs_d;
  logic                   phase_done, first, pwm_on, frame_origin;
  logic [CIW-1:0]         col;
  logic [PWM_BITS-1:0]    p;

  led_scan_timer #(
    .COLS         (COLS),
    .DWELL_BITS   (DWELL_BITS),
    .BLANK_CYCLES (BLANK_CYCLES),
    .PWM_BITS     (PWM_BITS)
  ) u_timer (
    .clk_i        (clk12MHz),
    .rst_i        (reset),
    .clr_i        (!enable),
    .show_i       (state_q == SHOW),
    .phase_done_o (phase_done),
    .first_o      (first),
    .col_o        (col),
    .p_o          (p)
  );

  always_comb begin
    state_d = state_q;
    if (phase_done) state_d = (state_q == BLANK) ? SHOW : BLANK;

    // The frame image is latched only at the first blank cycle of column 0.
    frame_origin = (state_q == BLANK) && (col == '0) && first;
    snap_d       = frame_origin ? leds_in : snap_q;

    pwm_on   = (brightness == '1) || (p < brightness);
    rows_act = '0;
    cols_act = '0;
    fs_d     = 1'b0;
    if (state_q == SHOW) begin
      rows_act = snap_q[32'(col)*ROWS +: ROWS] & {ROWS{pwm_on}};
      cols_act = COLS'(col_onehot(32'(col), COLS));
      fs_d     = (col == '0) && first;
    end

    if (!enable) begin
      state_d  = BLANK;
      snap_d   = '0;
      rows_act = '0;
      cols_act = '0;
      fs_d     = 1'b0;
    end

    leds_d = rows_act ^ ROW_OFF;
    lcol_d = cols_act ^ COL_OFF;
  end

  always_ff @(posedge clk12MHz or posedge reset) begin
    if (reset) begin
      state_q <= BLANK;
      snap_q  <= '0;
      leds_q  <= ROW_OFF;
      lcol_q  <= COL_OFF;
      fs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      leds_q  <= leds_d;
      lcol_q  <= lcol_d;
      fs_q    <= fs_d;
    end
  end

  assign leds        = leds_q;
  assign lcol        = lcol_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_led_scan_matrix.sv
// tb/tb_led_scan_matrix.sv - self-checking bench for led_scan_matrix
module tb_led_scan_matrix;

  typedef struct {
    logic [31:0] leds;
    logic [15:0] lcol;
    logic        fs;
  } exp_t;

  typedef struct {
    logic [3:0] bright;
    int         exp_on;
    int         exp_show;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, en_a, en_b;
  logic [31:0] in_a;
  logic [39:0] in_b;
  logic [3:0]  br_a, br_b;
  logic [7:0]  leds_a, leds_b;
  logic [3:0]  lcol_a;
  logic [4:0]  lcol_b;
  logic        fs_a, fs_b;

  int n_pass = 0;
  int n_chk  = 0;
  int wraps  = 0;

  exp_t qa[$];
  exp_t qb[$];
  vec_t tbl[6];

  logic [3:0] seq[4];
  logic [7:0] lv[4];
  int         seqn, fcnt, k, on, shows, bad;
  logic [3:0] prev;

  always #5 clk = ~clk;

  led_scan_matrix u_a (
    .clk12MHz(clk), .reset(rst), .enable(en_a), .leds_in(in_a), .brightness(br_a),
    .leds(leds_a), .lcol(lcol_a), .frame_start(fs_a)
  );

  led_scan_matrix #(
    .ROWS(8), .COLS(5), .DWELL_BITS(10), .BLANK_CYCLES(0), .PWM_BITS(4),
    .COL_ACTIVE_LOW(0), .ROW_ACTIVE_LOW(1)
  ) u_b (
    .clk12MHz(clk), .reset(rst), .enable(en_b), .leds_in(in_b), .brightness(br_b),
    .leds(leds_b), .lcol(lcol_b), .frame_start(fs_b)
  );

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  // Closed-form expectation: position within the frame decides column, phase and PWM slot.
  function automatic exp_t model(input int n, input int cols, input int blank, input int dbits,
                                 input int pbits, input bit cal, input bit ral,
                                 input logic [511:0] snap, input int bright, input bit idle);
    exp_t e;
    int b, d, plen, f, c, o, cnt, p;
    logic [31:0] ra, rmask;
    logic [15:0] ca, cmask;
    rmask = 32'hFF;
    cmask = (16'h1 << cols) - 16'h1;
    b = (blank == 0) ? 1 : blank;
    d = 1 << dbits;
    plen = b + d;
    ra = '0;
    ca = '0;
    e.fs = 1'b0;
    if (!idle) begin
      f = n % (cols * plen);
      c = f / plen;
      o = f % plen;
      if (o >= b) begin
        cnt = o - b;
        p = cnt >> (dbits - pbits);
        ca = 16'h1 << c;
        if (bright == (1 << pbits) - 1 || p < bright) ra = 32'(snap >> (c * 8)) & rmask;
        e.fs = (c == 0 && cnt == 0);
      end
    end
    e.leds = ral ? (~ra & rmask) : ra;
    e.lcol = cal ? (~ca & cmask) : ca;
    return e;
  endfunction

  initial begin : monitor
    int na, nb;
    logic [511:0] sa, sb;
    na = 0; nb = 0; sa = '0; sb = '0;
    forever begin
      @(posedge clk);
      if (rst || !en_a) begin
        qa.push_back(model(0, 4, 16, 10, 4, 1'b1, 1'b0, sa, 0, 1'b1));
        na = 0; sa = '0;
      end else begin
        qa.push_back(model(na, 4, 16, 10, 4, 1'b1, 1'b0, sa, int'(br_a), 1'b0));
        if (na % 4160 == 0) sa = 512'(in_a);
        na++;
      end
      if (rst || !en_b) begin
        qb.push_back(model(0, 5, 0, 10, 4, 1'b0, 1'b1, sb, 0, 1'b1));
        nb = 0; sb = '0;
      end else begin
        qb.push_back(model(nb, 5, 0, 10, 4, 1'b0, 1'b1, sb, int'(br_b), 1'b0));
        if (nb % 5125 == 0) sb = 512'(in_b);
        nb++;
      end
    end
  end

  initial begin : scoreboard
    exp_t e;
    forever begin
      @(negedge clk);
      if (qa.size() > 0) begin
        e = qa.pop_front();
        check("sb_a_leds", 64'(leds_a), 64'(e.leds));
        check("sb_a_lcol", 64'(lcol_a), 64'(e.lcol));
        check("sb_a_fs",   64'(fs_a),   64'(e.fs));
      end
      if (qb.size() > 0) begin
        e = qb.pop_front();
        check("sb_b_leds", 64'(leds_b), 64'(e.leds));
        check("sb_b_lcol", 64'(lcol_b), 64'(e.lcol));
        check("sb_b_fs",   64'(fs_b),   64'(e.fs));
      end
    end
  end

  initial begin : b_columns
    logic [4:0] last, nxt;
    int gap;
    last = '0; gap = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        last = '0; gap = 0;
      end else if (lcol_b == 5'h00) begin
        gap++;
      end else if (lcol_b != last) begin
        if (last == 5'h00) begin
          check("b_first_col", 64'(lcol_b), 64'h01);
        end else begin
          nxt = (last == 5'h10) ? 5'h01 : (last << 1);
          check("b_gap", 64'(gap), 64'd1);
          check("b_next_col", 64'(lcol_b), 64'(nxt));
          if (last == 5'h10) wraps++;
        end
        last = lcol_b; gap = 0;
      end
    end
  end

  task automatic wait_lcol_a(input logic [3:0] v, input string nm);
    int n;
    n = 0;
    while (lcol_a !== v && n < 6000) begin @(negedge clk); n++; end
    check(nm, 64'(n < 6000), 64'd1);
  endtask

  task automatic wait_fs_a(input string nm);
    int n;
    n = 0;
    while (fs_a !== 1'b1 && n < 6000) begin @(negedge clk); n++; end
    check(nm, 64'(n < 6000), 64'd1);
  endtask

  task automatic first_show(input string nm);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (lcol_a == 4'hF && n < 100);
    check(nm, 64'(n), 64'd17);
  endtask

  initial begin : main
    tbl[0] = '{4'h4, 256, 1024};
    tbl[1] = '{4'h0, 0, 1024};
    tbl[2] = '{4'h1, 64, 1024};
    tbl[3] = '{4'h8, 512, 1024};
    tbl[4] = '{4'hE, 896, 1024};
    tbl[5] = '{4'hF, 1024, 1024};

    rst = 1'b1; en_a = 1'b1; en_b = 1'b1;
    in_a = 32'h44332211; br_a = 4'hF;
    in_b = 40'h1008040201; br_b = 4'hF;
    repeat (3) @(negedge clk);
    check("rst_leds_a", 64'(leds_a), 64'h00);
    check("rst_lcol_a", 64'(lcol_a), 64'hF);
    check("rst_fs_a",   64'(fs_a),   64'h0);
    check("rst_leds_b", 64'(leds_b), 64'hFF);
    check("rst_lcol_b", 64'(lcol_b), 64'h00);

    @(negedge clk); rst = 1'b0;
    first_show("first_show_latency");
    check("first_leds", 64'(leds_a), 64'h11);
    check("first_fs",   64'(fs_a),   64'h1);

    prev = 4'hE; seqn = 0; fcnt = 0; k = 0;
    while (k < 4300) begin
      @(negedge clk); k++;
      if (lcol_a == 4'hF) fcnt++;
      else if (lcol_a != prev) begin
        if (seqn < 4) begin seq[seqn] = lcol_a; lv[seqn] = leds_a; end
        seqn++; prev = lcol_a;
      end
      if (fs_a) break;
    end
    check("frame_period", 64'(k), 64'd4160);
    check("blank_cycles", 64'(fcnt), 64'd64);
    check("seq_col1", 64'(seq[0]), 64'hD); check("seq_leds1", 64'(lv[0]), 64'h22);
    check("seq_col2", 64'(seq[1]), 64'hB); check("seq_leds2", 64'(lv[1]), 64'h33);
    check("seq_col3", 64'(seq[2]), 64'h7); check("seq_leds3", 64'(lv[2]), 64'h44);
    check("seq_col0", 64'(seq[3]), 64'hE); check("seq_leds0", 64'(lv[3]), 64'h11);

    for (int i = 0; i < 6; i++) begin
      wait_lcol_a(4'hD, $sformatf("tbl%0d_wait_col1", i));
      br_a = tbl[i].bright;
      wait_fs_a($sformatf("tbl%0d_wait_fs", i));
      on = 0; shows = 0; k = 0;
      while (lcol_a == 4'hE && k < 2000) begin
        shows++;
        if (leds_a != 8'h00) on++;
        @(negedge clk); k++;
      end
      check($sformatf("tbl%0d_on_cycles", i), 64'(on), 64'(tbl[i].exp_on));
      check($sformatf("tbl%0d_show_cycles", i), 64'(shows), 64'(tbl[i].exp_show));
    end

    wait_lcol_a(4'hB, "mid_wait_col2");
    in_a = 32'h88776655;
    wait_lcol_a(4'h7, "mid_wait_col3");
    check("mid_old_col3", 64'(leds_a), 64'h44);
    wait_fs_a("mid_wait_fs");
    check("mid_new_col0", 64'(leds_a), 64'h55);

    wait_lcol_a(4'hD, "rst_wait_col1");
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_leds", 64'(leds_a), 64'h00);
    check("async_rst_lcol", 64'(lcol_a), 64'hF);
    check("async_rst_lcol_b", 64'(lcol_b), 64'h00);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    first_show("rerst_show_latency");
    check("rerst_leds", 64'(leds_a), 64'h55);
    check("rerst_fs", 64'(fs_a), 64'h1);

    wait_lcol_a(4'h7, "en_wait_col3");
    repeat (5) @(negedge clk);
    en_a = 1'b0;
    in_a = 32'hA1B2C3D4;
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (lcol_a != 4'hF || leds_a != 8'h00 || fs_a) bad++;
    end
    check("disabled_inactive", 64'(bad), 64'd0);
    en_a = 1'b1;
    first_show("en_show_latency");
    check("en_fs", 64'(fs_a), 64'h1);
    check("en_col0", 64'(lcol_a), 64'hE);
    check("en_fresh_snap", 64'(leds_a), 64'hD4);

    repeat (20) @(negedge clk);
    check("b_wrap_seen", 64'(wraps > 0), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
